fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Fetch-stage initiator that drives byte addresses into the instruction memory and collects the returned 32-bit instructions into the IF/ID pipeline register. It owns the PC, sequences PC+4 and branch redirects, and runs a request/valid handshake so it works with any memory latency. It sits between the instruction memory and the decode stage, and applies decode back-pressure (stall).

Parameters:
RESET_PC, 0, byte address of the first fetch after reset; must be a multiple of 4.
ADDR_W, `WORD (64), PC and address width.
INSTR_W, `INSTR_LEN (32), instruction width.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  reset, asynchronous, active-high.
imem_req  output  1  request strobe to instruction memory, held high until imem_valid.
imem_addr  output  ADDR_W  fetch byte address; stable while imem_req is high.
imem_valid  input  1  memory response strobe; one-cycle pulse per accepted request.
imem_instr  input  INSTR_W  instruction data; qualified by imem_valid.
branch_taken  input  1  redirect request from a later stage; one-cycle pulse.
branch_target  input  ADDR_W  redirect address; qualified by branch_taken.
stall  input  1  decode not ready; hold the IF/ID contents.
if_valid  output  1  IF/ID holds a valid instruction.
if_pc  output  ADDR_W  address of the instruction in IF/ID.
if_instr  output  INSTR_W  instruction in IF/ID.

Behaviour:
- Reset (asynchronous, any state): pc=RESET_PC, state=REQ, squash=0, if_valid=0, if_pc=0, if_instr=0, imem_req=0, imem_addr=RESET_PC.
- FSM states:
  - REQ: drive imem_req=1 and imem_addr=pc. Go to WAIT on the next edge.
  - WAIT: keep imem_req=1 and the address stable until imem_valid. On imem_valid with squash=0: if the IF/ID slot is free (if_valid=0 or stall=0), load the slot (if_instr=imem_instr, if_pc=pc, if_valid=1), set pc=pc+4, go to REQ. If the slot is occupied and stall=1, capture the data into a one-entry skid register and go to HOLD.
  - HOLD: imem_req=0. When stall=0, move the skid register into IF/ID, set pc=pc+4, go to REQ.
- Throughput: one instruction per 2 cycles with zero-latency memory. Latency from imem_valid to if_valid is 1 cycle.
- stall=1: the IF/ID outputs hold. If the slot is being consumed (stall=0) and no new data arrives, if_valid drops to 0.
- Redirect (branch_taken=1):
  - Always clear if_valid at the next edge, and set pc=branch_target.
  - In REQ or HOLD: discard any skid data and go to REQ.
  - In WAIT without same-cycle imem_valid: set squash=1. The outstanding response is dropped on arrival, then the FSM goes to REQ at branch_target and clears squash.
  - In WAIT with same-cycle imem_valid: drop that data and go to REQ directly.
  - Redirect has priority over stall.
- PC arithmetic: modulo 2^ADDR_W; wrap from all-ones-minus-3 to 0 is legal. branch_target[1:0] is forced to 00.
- Simultaneous reset and anything: reset wins.
- Reset mid-WAIT: the late imem_valid after reset deasserts is ignored, because state is REQ and imem_req=0.

Test Plan:
- Reset with RESET_PC=0, 0-latency memory preloaded ABCDEF12, BCDEF123, CDEF1234 at 0/4/8 -> imem_addr sequence 0,4,8; IF/ID shows (0,ABCDEF12), (4,BCDEF123), (8,CDEF1234); if_valid high one cycle per fetch.
- stall held for 5 cycles while (4,BCDEF123) is in IF/ID -> outputs unchanged for 5 cycles, imem_req=0 in HOLD; on release, (8,CDEF1234) appears next cycle with no lost or duplicated instruction.
- branch_taken with target 52 while idle in REQ -> if_valid=0 next cycle, next imem_addr=52, IF/ID=(52,89ABCDEF), then 56 -> 9ABCDEF1.
- 3-cycle memory latency, branch_taken to 28 during WAIT for addr 16 -> data for 16 (EF123456) never reaches IF/ID; next request addr=28, IF/ID=(28,23456789).
- rst asserted mid-WAIT, deasserted, then a stale imem_valid -> ignored; first fetch at RESET_PC.
- Wrap: RESET_PC=2^64-4 -> second imem_addr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues request/valid fetches to the
// instruction memory, handles branch redirects (squashing late responses),
// and fills the IF/ID register with a one-entry skid buffer for decode stalls.
module fetch_unit #(
  parameter int unsigned         ADDR_W   = 64,
  parameter int unsigned         INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP    = {{(ADDR_W-3){1'b0}}, 3'b100};
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t               state_r,     state_nxt_s;
  logic [ADDR_W-1:0]    pc_r,        pc_nxt_s;
  logic                 squash_r,    squash_nxt_s;
  logic [INSTR_W-1:0]   skid_r,      skid_nxt_s;
  logic                 if_valid_r,  if_valid_nxt_s;
  logic [ADDR_W-1:0]    if_pc_r,     if_pc_nxt_s;
  logic [INSTR_W-1:0]   if_instr_r,  if_instr_nxt_s;
  logic                 imem_req_r,  imem_req_nxt_s;
  logic [ADDR_W-1:0]    imem_addr_r, imem_addr_nxt_s;

  logic [ADDR_W-1:0]    target_s;
  logic                 slot_free_s;

  // Redirect target is word aligned; IF/ID may accept new data when empty or draining.
  always_comb begin
    target_s    = branch_target & ALIGN_MASK;
    slot_free_s = !if_valid_r || !stall;
  end

  // Next-state and next-output logic for the fetch sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    pc_nxt_s        = pc_r;
    squash_nxt_s    = squash_r;
    skid_nxt_s      = skid_r;
    if_pc_nxt_s     = if_pc_r;
    if_instr_nxt_s  = if_instr_r;
    imem_req_nxt_s  = imem_req_r;
    imem_addr_nxt_s = imem_addr_r;
    // Decode consumes the slot whenever it is not stalled.
    if (stall) begin
      if_valid_nxt_s = if_valid_r;
    end else begin
      if_valid_nxt_s = 1'b0;
    end

    case (state_r)
      ST_REQ: begin
        if (branch_taken) begin
          pc_nxt_s       = target_s;
          if_valid_nxt_s = 1'b0;
          imem_req_nxt_s = 1'b0;
          state_nxt_s    = ST_REQ;
        end else begin
          imem_req_nxt_s  = 1'b1;
          imem_addr_nxt_s = pc_r;
          state_nxt_s     = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (branch_taken) begin
          pc_nxt_s       = target_s;
          if_valid_nxt_s = 1'b0;
          if (imem_valid) begin
            // Response for the old path arrives now: drop it and refetch.
            imem_req_nxt_s = 1'b0;
            squash_nxt_s   = 1'b0;
            state_nxt_s    = ST_REQ;
          end else begin
            // Keep the request open; its response will be discarded.
            squash_nxt_s   = 1'b1;
          end
        end else if (imem_valid) begin
          imem_req_nxt_s = 1'b0;
          if (squash_r) begin
            squash_nxt_s = 1'b0;
            state_nxt_s  = ST_REQ;
          end else if (slot_free_s) begin
            if_valid_nxt_s = 1'b1;
            if_pc_nxt_s    = pc_r;
            if_instr_nxt_s = imem_instr;
            pc_nxt_s       = pc_r + PC_STEP;
            state_nxt_s    = ST_REQ;
          end else begin
            skid_nxt_s  = imem_instr;
            state_nxt_s = ST_HOLD;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end

      ST_HOLD: begin
        if (branch_taken) begin
          pc_nxt_s       = target_s;
          if_valid_nxt_s = 1'b0;
          state_nxt_s    = ST_REQ;
        end else if (!stall) begin
          if_valid_nxt_s = 1'b1;
          if_pc_nxt_s    = pc_r;
          if_instr_nxt_s = skid_r;
          pc_nxt_s       = pc_r + PC_STEP;
          state_nxt_s    = ST_REQ;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end

      default: begin
        imem_req_nxt_s = 1'b0;
        squash_nxt_s   = 1'b0;
        state_nxt_s    = ST_REQ;
      end
    endcase
  end

  // State, PC, skid and IF/ID registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_REQ;
      pc_r        <= RESET_PC;
      squash_r    <= 1'b0;
      skid_r      <= {INSTR_W{1'b0}};
      if_valid_r  <= 1'b0;
      if_pc_r     <= {ADDR_W{1'b0}};
      if_instr_r  <= {INSTR_W{1'b0}};
      imem_req_r  <= 1'b0;
      imem_addr_r <= RESET_PC;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      squash_r    <= squash_nxt_s;
      skid_r      <= skid_nxt_s;
      if_valid_r  <= if_valid_nxt_s;
      if_pc_r     <= if_pc_nxt_s;
      if_instr_r  <= if_instr_nxt_s;
      imem_req_r  <= imem_req_nxt_s;
      imem_addr_r <= imem_addr_nxt_s;
    end
  end

  assign imem_req  = imem_req_r;
  assign imem_addr = imem_addr_r;
  assign if_valid  = if_valid_r;
  assign if_pc     = if_pc_r;
  assign if_instr  = if_instr_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected fetch
// addresses and IF/ID contents; monitors pop and compare on DUT events.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_instr;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        stall;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;

  logic        rst2;
  logic        imem_req2;
  logic [63:0] imem_addr2;
  logic        if_valid2;
  logic [63:0] if_pc2;
  logic [31:0] if_instr2;

  int          total = 0;
  int          bad   = 0;
  int          lat   = 0;
  int          wcnt  = 0;
  logic        force_valid;
  logic [32:0] mem_word;

  logic [63:0] aq[$];
  logic [95:0] dq[$];
  logic [63:0] aq2[$];
  logic [63:0] dq2[$];

  logic        req_prev  = 1'b0;
  logic [63:0] addr_prev = 64'd0;
  logic        hold_prev = 1'b0;
  logic [63:0] hpc_prev  = 64'd0;
  logic [31:0] hins_prev = 32'd0;
  logic        req2_prev = 1'b0;

  fetch_unit #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'd0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_instr(imem_instr),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
  );

  fetch_unit #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_valid(imem_req2), .imem_instr(32'h0000_0000),
    .branch_taken(1'b0), .branch_target(64'd0),
    .stall(1'b0),
    .if_valid(if_valid2), .if_pc(if_pc2), .if_instr(if_instr2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents; bit 32 marks a present word.
  function automatic logic [32:0] mem_rd(input logic [63:0] a);
    case (a)
      64'd0:   return {1'b1, 32'hABCD_EF12};
      64'd4:   return {1'b1, 32'hBCDE_F123};
      64'd8:   return {1'b1, 32'hCDEF_1234};
      64'd16:  return {1'b1, 32'hEF12_3456};
      64'd28:  return {1'b1, 32'h2345_6789};
      64'd52:  return {1'b1, 32'h89AB_CDEF};
      64'd56:  return {1'b1, 32'h9ABC_DEF1};
      default: return {1'b0, 32'h0000_0000};
    endcase
  endfunction

  assign mem_word   = mem_rd(imem_addr);
  assign imem_instr = mem_word[31:0];
  assign imem_valid = force_valid || (imem_req && mem_word[32] && (wcnt >= lat));

  // Memory latency counter: cycles the current request has been pending.
  always @(posedge clk) begin
    if (!imem_req || imem_valid) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Main DUT monitor: fetch addresses, address stability, IF/ID handoffs, stall hold.
  always @(negedge clk) begin
    if (imem_req && !req_prev) begin
      if (aq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_req: got addr %h required no request", imem_addr);
      end else begin
        chk("imem_addr", imem_addr, aq[0]);
        void'(aq.pop_front());
      end
    end
    if (imem_req && req_prev) chk("addr_stable", imem_addr, addr_prev);
    if (hold_prev && !rst) begin
      chk("stall_hold_valid", {63'd0, if_valid}, 64'd1);
      chk("stall_hold_pc", if_pc, hpc_prev);
      chk("stall_hold_instr", {32'd0, if_instr}, {32'd0, hins_prev});
    end
    if (if_valid && !stall) begin
      if (dq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ifid: got pc %h instr %h required none", if_pc, if_instr);
      end else begin
        chk("if_pc", if_pc, dq[0][95:32]);
        chk("if_instr", {32'd0, if_instr}, {32'd0, dq[0][31:0]});
        void'(dq.pop_front());
      end
    end
    req_prev  <= imem_req;
    addr_prev <= imem_addr;
    hold_prev <= if_valid && stall && !rst;
    hpc_prev  <= if_pc;
    hins_prev <= if_instr;
  end

  // Wrap-around instance monitor: first requests and IF/ID PCs only.
  always @(negedge clk) begin
    if (imem_req2 && !req2_prev && aq2.size() != 0) begin
      chk("wrap_addr", imem_addr2, aq2[0]);
      void'(aq2.pop_front());
    end
    if (if_valid2 && dq2.size() != 0) begin
      chk("wrap_if_pc", if_pc2, dq2[0]);
      void'(dq2.pop_front());
    end
    req2_prev <= imem_req2;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int kind, input logic [63:0] a, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc();
      case (kind)
        0:       hit = imem_req;
        1:       hit = imem_req && (imem_addr == a);
        default: hit = if_valid && (if_pc == a);
      endcase
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s: event not seen within 100 cycles, required it", nm);
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((aq.size() != 0 || dq.size() != 0) && n < 300) begin
      cyc();
      n++;
    end
    total++;
    if (aq.size() != 0 || dq.size() != 0) begin
      bad++;
      $display("FAIL %s: pending addr=%0d data=%0d required 0", nm, aq.size(), dq.size());
    end
    repeat (6) cyc();
    aq.delete();
    dq.delete();
  endtask

  task automatic restart(input int latency);
    rst = 1'b1;
    cyc();
    lat = latency;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; stall = 1'b0; force_valid = 1'b0;
    branch_taken = 1'b0; branch_target = 64'd0;
    aq2.push_back(64'hFFFF_FFFF_FFFF_FFFC); aq2.push_back(64'd0);
    dq2.push_back(64'hFFFF_FFFF_FFFF_FFFC); dq2.push_back(64'd0);
    repeat (2) cyc();
    chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
    chk("rst_if_pc", if_pc, 64'd0);
    chk("rst_if_instr", {32'd0, if_instr}, 64'd0);
    chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
    chk("rst_imem_addr", imem_addr, 64'd0);
    chk("rst_wrap_addr", imem_addr2, 64'hFFFF_FFFF_FFFF_FFFC);
    rst2 = 1'b0;

    // Sequential fetch, zero latency.
    aq = '{64'd0, 64'd4, 64'd8, 64'd12};
    dq = '{{64'd0, 32'hABCD_EF12}, {64'd4, 32'hBCDE_F123}, {64'd8, 32'hCDEF_1234}};
    rst = 1'b0;
    drain("seq_drain");

    // Decode stall for 5 cycles while (4,BCDEF123) sits in IF/ID.
    restart(0);
    aq = '{64'd0, 64'd4, 64'd8, 64'd12};
    dq = '{{64'd0, 32'hABCD_EF12}, {64'd4, 32'hBCDE_F123}, {64'd8, 32'hCDEF_1234}};
    rst = 1'b0;
    wait_until(2, 64'd4, "stall_wait");
    stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i >= 2) chk("hold_imem_req", {63'd0, imem_req}, 64'd0);
    end
    stall = 1'b0;
    drain("stall_drain");

    // Redirect to 52 in the first REQ cycle.
    restart(0);
    aq = '{64'd52, 64'd56, 64'd60};
    dq = '{{64'd52, 32'h89AB_CDEF}, {64'd56, 32'h9ABC_DEF1}};
    rst = 1'b0;
    branch_taken = 1'b1; branch_target = 64'd52;
    cyc();
    branch_taken = 1'b0;
    chk("req_branch_if_valid", {63'd0, if_valid}, 64'd0);
    chk("req_branch_imem_req", {63'd0, imem_req}, 64'd0);
    drain("req_branch_drain");

    // 3-cycle latency: redirect to 28 while waiting on 16; response for 16 dropped.
    restart(3);
    aq = '{64'd16, 64'd28, 64'd32};
    dq = '{{64'd28, 32'h2345_6789}};
    rst = 1'b0;
    branch_taken = 1'b1; branch_target = 64'd16;
    cyc();
    branch_taken = 1'b0;
    wait_until(0, 64'd0, "squash_wait");
    branch_taken = 1'b1; branch_target = 64'd28;
    cyc();
    branch_taken = 1'b0;
    chk("squash_req_held", {63'd0, imem_req}, 64'd1);
    chk("squash_addr_held", imem_addr, 64'd16);
    chk("squash_if_valid", {63'd0, if_valid}, 64'd0);
    drain("squash_drain");

    // Reset mid-WAIT followed by a stale response.
    restart(3);
    aq = '{64'd0, 64'd0, 64'd4, 64'd8, 64'd12};
    dq = '{{64'd0, 32'hABCD_EF12}, {64'd4, 32'hBCDE_F123}, {64'd8, 32'hCDEF_1234}};
    rst = 1'b0;
    wait_until(0, 64'd0, "midwait_wait");
    cyc();
    rst = 1'b1;
    cyc();
    chk("midwait_rst_req", {63'd0, imem_req}, 64'd0);
    cyc();
    rst = 1'b0;
    force_valid = 1'b1;
    cyc();
    force_valid = 1'b0;
    chk("stale_if_valid", {63'd0, if_valid}, 64'd0);
    chk("stale_req", {63'd0, imem_req}, 64'd1);
    chk("stale_addr", imem_addr, 64'd0);
    drain("midwait_drain");

    // Redirect with same-cycle response; unaligned target 55 aligns to 52.
    restart(0);
    aq = '{64'd0, 64'd4, 64'd52, 64'd56, 64'd60};
    dq = '{{64'd0, 32'hABCD_EF12}, {64'd52, 32'h89AB_CDEF}, {64'd56, 32'h9ABC_DEF1}};
    rst = 1'b0;
    wait_until(1, 64'd4, "samecyc_wait");
    branch_taken = 1'b1; branch_target = 64'd55;
    cyc();
    branch_taken = 1'b0;
    chk("samecyc_if_valid", {63'd0, if_valid}, 64'd0);
    drain("samecyc_drain");

    total++;
    if (aq2.size() != 0 || dq2.size() != 0) begin
      bad++;
      $display("FAIL wrap_pending: addr=%0d data=%0d required 0", aq2.size(), dq2.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
